// File: rtl/read_fifo_fsm.sv
`default_nettype none
// ============================================================================
// Module   : read_fifo_fsm
// Purpose  : Drains one packet of pkt_words words from a normal-mode FIFO
//            (1-cycle read latency) and presents it as a streaming source with
//            SOP/EOP framing under ready backpressure. A 2-entry register
//            buffer absorbs the FIFO read latency so the stream can run at one
//            word per cycle without losing data when the sink stalls.
// Ports    : src_clock, src_reset_n  - clock, async active-low reset
//            start, pkt_words        - launch pulse and packet length
//            fifo_q, fifo_empty      - FIFO read data / empty flag
//            rd_fifo                 - FIFO read request (combinational)
//            src_data/valid/sop/eop  - streaming source outputs
//            src_ready               - downstream accept
//            src_done, src_busy      - completion pulse / activity flag
// Revision : 1.0 - initial release
// ============================================================================
module read_fifo_fsm #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              src_clock,
    input  logic              src_reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  pkt_words,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              rd_fifo,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic              src_done,
    output logic              src_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    state_t              r_state;
    logic [1:0]          r_occ;        // words held in the output buffer
    logic                r_inflight;   // a FIFO read was issued last cycle
    logic [CNT_W-1:0]    r_rd_left;    // words still to be read from the FIFO
    logic [CNT_W-1:0]    r_tx_left;    // words still to be accepted downstream
    logic                r_first;
    logic [DATA_W-1:0]   r_buf0;       // head entry
    logic [DATA_W-1:0]   r_buf1;

    logic                w_valid;
    logic                w_pop;
    logic                w_credit_ok;
    logic                w_rd;

    assign w_valid = (r_occ != 2'd0);
    assign w_pop   = w_valid && src_ready;

    // A read may only be issued if the word it returns is guaranteed a slot:
    // words held + word already in flight - word leaving this cycle < 2.
    // Written as an addition on both sides to avoid unsigned underflow.
    assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    assign w_rd = (r_state == S_READ) && !fifo_empty && (r_rd_left != c_ZERO) && w_credit_ok;

    always_ff @(posedge src_clock or negedge src_reset_n) begin
        if (!src_reset_n) begin
            r_state    <= S_IDLE;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_rd_left  <= c_ZERO;
            r_tx_left  <= c_ZERO;
            r_first    <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_rd;

            // Output buffer: push the word returned by last cycle's read,
            // pop the head on an accepted beat.
            if (r_inflight && w_pop) begin
                if (r_occ == 2'd2) begin
                    r_buf0 <= r_buf1;
                    r_buf1 <= fifo_q;
                end else begin
                    r_buf0 <= fifo_q;
                end
            end else if (r_inflight) begin
                if (r_occ == 2'd0) begin
                    r_buf0 <= fifo_q;
                end else begin
                    r_buf1 <= fifo_q;
                end
                r_occ <= r_occ + 2'd1;
            end else if (w_pop) begin
                r_buf0 <= r_buf1;
                r_occ  <= r_occ - 2'd1;
            end

            if (w_pop) begin
                r_first   <= 1'b0;
                r_tx_left <= r_tx_left - c_ONE;
            end

            if (w_rd) begin
                r_rd_left <= r_rd_left - c_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    // A zero-length launch is dropped without leaving IDLE.
                    if (start && (pkt_words != c_ZERO)) begin
                        r_state   <= S_READ;
                        r_rd_left <= pkt_words;
                        r_tx_left <= pkt_words;
                        r_first   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_rd && (r_rd_left == c_ONE)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_tx_left == c_ONE)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_fifo   = w_rd;
    assign src_data  = r_buf0;
    assign src_valid = w_valid;
    assign src_sop   = w_valid && r_first;
    assign src_eop   = w_valid && (r_tx_left == c_ONE);
    assign src_done  = (r_state == S_DONE);
    assign src_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_read_fifo_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_fifo_fsm
// Purpose  : Self-checking bench for read_fifo_fsm. A behavioural FIFO feeds
//            the DUT from a word array; a packet-level scoreboard checks the
//            delivered words, framing, completion pulse and read credit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_fifo_fsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] pkt_words;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic        rd_fifo;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic        src_ready;
    logic        src_done;
    logic        src_busy;

    read_fifo_fsm #(.DATA_W(32), .CNT_W(16)) u_dut (
        .src_clock   (clk),
        .src_reset_n (rst_n),
        .start       (start),
        .pkt_words   (pkt_words),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .rd_fifo     (rd_fifo),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .src_ready   (src_ready),
        .src_done    (src_done),
        .src_busy    (src_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural FIFO ----------------
    logic [31:0] mem [0:4095];
    int          len_mem [0:1023];
    int          pushed_cnt;
    int          popped_cnt;
    int          pkt_launched;
    logic        force_empty;

    assign fifo_empty = force_empty || (popped_cnt >= pushed_cnt);

    always @(posedge clk) begin
        if (!rst_n) begin
            popped_cnt <= pushed_cnt;   // discard words of an aborted packet
            fifo_q     <= 32'h0;
        end else if (rd_fifo) begin
            if (popped_cnt < pushed_cnt) fifo_q <= mem[popped_cnt];
            else                         fifo_q <= 32'hDEAD_BEEF;
            popped_cnt <= popped_cnt + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_tests;
    int n_fail;

    int   rdy_mode;   // 0: always ready, 1: random, 2: never
    logic fe_rand;
    logic fe_force;
    logic fake_en;

    // scoreboard state
    int          acc_ptr;
    int          pkt_seen;
    int          beat_idx;
    int          rd_in_pkt;
    int          outst;
    int          last_len;
    logic        exp_done;
    logic        exp_idle;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_sop;
    logic        prev_eop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            mem[pushed_cnt] = (base != 32'h0) ? (base + 32'(i)) : $urandom;
            pushed_cnt++;
        end
        len_mem[pkt_launched] = len;
        pkt_launched++;
    endtask

    // Packet-level scoreboard, evaluated once per cycle away from the edge.
    task automatic mon();
        logic [31:0] exp_word;
        int          len;
        if (!rst_n) begin
            acc_ptr    = pushed_cnt;
            pkt_seen   = pkt_launched;
            beat_idx   = 0;
            rd_in_pkt  = 0;
            outst      = 0;
            exp_done   = 1'b0;
            exp_idle   = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("stall_hold", {src_valid, src_sop, src_eop, src_data},
                {1'b1, prev_sop, prev_eop, prev_data});
        end
        if (exp_done) begin
            chk("done_pulse", src_done, 1'b1);
            chk("pkt_reads", rd_in_pkt, last_len);
            rd_in_pkt = 0;
            exp_done  = 1'b0;
            exp_idle  = 1'b1;
        end else if (exp_idle) begin
            chk("busy_fall", {src_busy, src_done}, 2'b00);
            exp_idle = 1'b0;
        end else if (src_done) begin
            chk("done_spurious", src_done, 1'b0);
        end
        chk("frame_qual", {src_sop, src_eop} & {2{~src_valid}}, 2'b00);
        if (rd_fifo) begin
            chk("rd_while_empty", fifo_empty, 1'b0);
            rd_in_pkt++;
            outst++;
        end
        if (src_valid && src_ready) begin
            if (pkt_seen >= pkt_launched) begin
                chk("beat_unexpected", 1'b1, 1'b0);
            end else begin
                len      = len_mem[pkt_seen];
                exp_word = mem[acc_ptr];
                chk($sformatf("beat_p%0d_w%0d", pkt_seen, beat_idx),
                    {src_data, src_sop, src_eop},
                    {exp_word, (beat_idx == 0), (beat_idx == len - 1)});
                acc_ptr++;
                beat_idx++;
                if (beat_idx == len) begin
                    last_len = len;
                    pkt_seen++;
                    beat_idx = 0;
                    exp_done = 1'b1;
                end
            end
            outst--;
        end
        if (rd_fifo) chk("rd_credit", (outst <= 2), 1'b1);
        prev_stall = src_valid && !src_ready;
        prev_data  = src_data;
        prev_sop   = src_sop;
        prev_eop   = src_eop;
    endtask

    // One clock cycle: drive at the falling edge, observe 2 ns later.
    task automatic step(input logic st, input logic [15:0] pw);
        @(negedge clk);
        if (st) begin
            start     = 1'b1;
            pkt_words = pw;
        end else if (fake_en && src_busy && ($urandom_range(0, 5) == 0)) begin
            start     = 1'b1;
            pkt_words = 16'($urandom_range(1, 20));
        end else begin
            start     = 1'b0;
            pkt_words = 16'($urandom_range(0, 65535));
        end
        case (rdy_mode)
            0:       src_ready = 1'b1;
            1:       src_ready = ($urandom_range(0, 2) != 0);
            default: src_ready = 1'b0;
        endcase
        force_empty = fe_force || (fe_rand && ($urandom_range(0, 4) == 0));
        #2;
        mon();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!src_done && n < budget) begin
            step(1'b0, 16'd0);
            n++;
        end
        if (!src_done) chk("timeout_done", 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (src_busy && n < budget) begin
            step(1'b0, 16'd0);
            n++;
        end
        if (src_busy) chk("timeout_idle", 1'b1, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        st;
        logic [15:0] pw;
        logic [5:0]  ctl;   // {rd_fifo, valid, sop, eop, done, busy}
        logic [31:0] data;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, seen0, gaps, stall_left, len;
        logic stalled;

        // 4-word packet A0..A3, zero-length launch, then 1-word packet B0
        tbl[0]  = '{1'b1, 16'd4, 6'b000000, 32'h0};
        tbl[1]  = '{1'b0, 16'd0, 6'b100001, 32'h0};
        tbl[2]  = '{1'b0, 16'd0, 6'b100001, 32'h0};
        tbl[3]  = '{1'b0, 16'd0, 6'b111001, 32'hA000_0000};
        tbl[4]  = '{1'b0, 16'd0, 6'b110001, 32'hA000_0001};
        tbl[5]  = '{1'b0, 16'd0, 6'b010001, 32'hA000_0002};
        tbl[6]  = '{1'b0, 16'd0, 6'b010101, 32'hA000_0003};
        tbl[7]  = '{1'b0, 16'd0, 6'b000011, 32'h0};
        tbl[8]  = '{1'b0, 16'd0, 6'b000000, 32'h0};
        tbl[9]  = '{1'b1, 16'd0, 6'b000000, 32'h0};
        tbl[10] = '{1'b0, 16'd0, 6'b000000, 32'h0};
        tbl[11] = '{1'b0, 16'd0, 6'b000000, 32'h0};
        tbl[12] = '{1'b1, 16'd1, 6'b000000, 32'h0};
        tbl[13] = '{1'b0, 16'd0, 6'b100001, 32'h0};
        tbl[14] = '{1'b0, 16'd0, 6'b000001, 32'h0};
        tbl[15] = '{1'b0, 16'd0, 6'b011101, 32'hB000_0000};
        tbl[16] = '{1'b0, 16'd0, 6'b000011, 32'h0};
        tbl[17] = '{1'b0, 16'd0, 6'b000000, 32'h0};

        n_tests = 0;   n_fail = 0;
        pushed_cnt = 0; pkt_launched = 0;
        rdy_mode = 0;  fe_rand = 1'b0; fe_force = 1'b0; fake_en = 1'b0;
        force_empty = 1'b0;
        start = 1'b0;  pkt_words = 16'd0; src_ready = 1'b1;
        rst_n = 1'b0;

        step(1'b0, 16'd0);
        chk("reset_outputs", {rd_fifo, src_valid, src_sop, src_eop, src_done, src_busy, src_data}, 38'h0);
        step(1'b0, 16'd0);
        rst_n = 1'b1;
        step(1'b0, 16'd0);

        push_pkt(4, 32'hA000_0000);
        push_pkt(1, 32'hB000_0000);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].st, tbl[i].pw);
            chk($sformatf("vec%0d_ctl", i),
                {rd_fifo, src_valid, src_sop, src_eop, src_done, src_busy}, tbl[i].ctl);
            if (tbl[i].ctl[4]) chk($sformatf("vec%0d_data", i), src_data, tbl[i].data);
        end

        // FIFO runs dry mid-packet; a second start arrives mid-packet.
        wait_idle(20);
        base = pushed_cnt; seen0 = pkt_seen;
        push_pkt(5, 32'h0);
        step(1'b1, 16'd5);
        gaps = 0; stall_left = 3; stalled = 1'b0;
        for (int k = 0; k < 60 && !src_done; k++) begin
            if (!stalled && popped_cnt >= base + 2) fe_force = 1'b1;
            step(k == 2, 16'd7);
            if (fe_force) begin
                stall_left--;
                if (stall_left == 0) begin
                    fe_force = 1'b0;
                    stalled  = 1'b1;
                end
            end
            if (beat_idx > 0 && !src_valid) gaps++;
        end
        fe_force = 1'b0;
        if (!src_done) chk("timeout_stall", 1'b0, 1'b1);
        chk("stall_gap_seen", (gaps > 0), 1'b1);
        step(1'b0, 16'd0);
        chk("stall_pkts", pkt_seen - seen0, 1);
        chk("stall_reads", popped_cnt - base, 5);

        // Reset in the middle of a 6-word packet, then a 2-word packet.
        wait_idle(20);
        push_pkt(6, 32'h0);
        step(1'b1, 16'd6);
        for (int k = 0; k < 4; k++) step(1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {rd_fifo, src_valid, src_sop, src_eop, src_done, src_busy, src_data}, 38'h0);
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        rst_n = 1'b1;
        step(1'b0, 16'd0);
        seen0 = pkt_seen;
        push_pkt(2, 32'h0);
        step(1'b1, 16'd2);
        wait_done(50);
        step(1'b0, 16'd0);
        chk("post_reset_pkt", pkt_seen - seen0, 1);

        // Backpressure on an 8-word packet.
        rdy_mode = 1;
        wait_idle(20);
        push_pkt(8, 32'h0);
        step(1'b1, 16'd8);
        wait_done(300);

        // Random packets, random stalls on both sides, stray starts.
        fake_en = 1'b1;
        fe_rand = 1'b1;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 12);
            push_pkt(len, 32'h0);
            step(1'b1, 16'(len));   // cycle right after DONE: state is IDLE
            wait_done(400);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 16'd0);
        end
        fake_en = 1'b0;
        fe_rand = 1'b0;
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        chk("all_pkts_delivered", pkt_seen, pkt_launched);
        chk("final_idle", {src_busy, src_valid}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/read_fifo_fsm.md
# read_fifo_fsm

Source-side packet reader that drains one packet of exactly `pkt_words` words from a normal-mode (1-cycle read latency) FIFO and emits it as a streaming source with `src_valid`/`src_sop`/`src_eop` framing under `src_ready` backpressure. It pairs with the sink-side write FSM: a packet the sink side has completely written into the FIFO is launched here by a `start` pulse carrying its word count. A 2-entry output buffer absorbs the FIFO read latency, giving 1 word/cycle throughput with no data loss on backpressure.

## Interface
- `DATA_W`, 32, data width of FIFO and source bus
- `CNT_W`, 16, width of packet word counters; maximum packet length 2^CNT_W-1 words

Ports:
- `src_clock`  in  1  single clock; all logic on its rising edge
- `src_reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse: a complete packet is in the FIFO
- `pkt_words`  in  CNT_W  packet length in words, sampled with `start`
- `fifo_q`  in  DATA_W  FIFO read data, valid the cycle after `rd_fifo`
- `fifo_empty`  in  1  FIFO empty flag
- `rd_fifo`  out  1  FIFO read request (combinational)
- `src_data`  out  DATA_W  output word
- `src_valid`  out  1  `src_data` valid
- `src_sop`  out  1  first word of packet; qualified by `src_valid`
- `src_eop`  out  1  last word of packet; qualified by `src_valid`
- `src_ready`  in  1  downstream accepts the word when `src_valid && src_ready`
- `src_done`  out  1  one-cycle pulse, packet fully transmitted
- `src_busy`  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, READ, DRAIN, DONE. Encoding 2 bits; an illegal state goes to IDLE.
- IDLE: when `start` is high and `pkt_words` != 0, go to READ. Load `rd_left` and `tx_left` with `pkt_words`, and set `first` = 1. If `start` is high with `pkt_words` == 0, stay in IDLE with no activity.
- `start` outside IDLE is ignored.
- READ: `rd_fifo` = `!fifo_empty && rd_left != 0 && (occ + inflight - pop) < 2`.
  - `occ` is the buffer occupancy (0..2).
  - `inflight` is a register holding the previous cycle's `rd_fifo`.
  - `pop` = `src_valid && src_ready`.
  - Each `rd_fifo` decrements `rd_left`.
  - Go to DRAIN when `rd_fifo` is high and `rd_left` == 1.
- DRAIN: no reads. Go to DONE when `pop` occurs while `tx_left` == 1.
- DONE: lasts one cycle, then goes to IDLE.
- Buffer: 2-entry FIFO of registers. An entry is written when `inflight` is high (captures `fifo_q`); the head is popped on `pop`. A simultaneous push and pop keeps `occ` unchanged. The credit rule guarantees `occ` never exceeds 2.
- `src_valid` = `occ != 0`. `src_data` = head entry.
- `src_sop` = `src_valid && first`. `first` clears on the first `pop`.
- `src_eop` = `src_valid && tx_left == 1`. `tx_left` decrements on each `pop`.
- Single-word packet: `src_sop` and `src_eop` are high on the same beat.
- `fifo_empty` during a packet stalls reads only. `src_valid` may drop between words; a gap is legal within a packet. `src_sop` and `src_eop` are never repeated.
- `src_ready` low: `src_data`, `src_sop` and `src_eop` are held stable while `src_valid` is high.
- `src_busy` = state != IDLE.
- `src_done` = (state == DONE).

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE.
  - `occ`, `inflight`, `rd_left`, `tx_left` = 0; `first` = 0; buffer data = 0.
  - Outputs `rd_fifo`, `src_valid`, `src_sop`, `src_eop`, `src_done`, `src_busy` = 0; `src_data` = 0.
- Reset mid-packet aborts the packet. Unread FIFO words are not flushed by this block.
- Latency, with a non-empty FIFO and `src_ready` = 1:
  - `start` sampled in cycle 0.
  - `rd_fifo` = 1 in cycle 1.
  - Word captured at the end of cycle 2.
  - `src_valid` and `src_sop` = 1 in cycle 3.
- Throughput: 1 word/cycle when `src_ready` is held high and the FIFO is not empty. `rd_fifo` stays high continuously.
- `src_done` is high exactly one cycle, in the cycle after the `src_eop` beat is accepted. `src_busy` falls in the cycle after that.
- Earliest accepted next `start`: the cycle after DONE (state IDLE).

## Test plan
- Basic 4-word packet (words A0..A3), `src_ready` = 1, `start` in cycle 0:
  - Beats in cycles 3..6.
  - `src_sop` only on A0; `src_eop` only on A3.
  - `rd_fifo` high in cycles 1..4.
  - `src_done` in cycle 7; `src_busy` = 0 in cycle 8.
- Single-word packet, `pkt_words` = 1 → one beat with `src_sop` = `src_eop` = 1; exactly one `rd_fifo`; `src_done` one cycle later.
- Backpressure, 8-word packet with `src_ready` toggled pseudo-randomly:
  - Output sequence is exactly the 8 written words, none dropped or duplicated.
  - Data stays stable while stalled.
  - `rd_fifo` is never issued when `occ + inflight` would exceed 2.
- `fifo_empty` asserted for 3 cycles after word 2 of a 5-word packet → `src_valid` gaps, no extra `src_sop`/`src_eop`, `src_eop` on word 5.
- `start` with `pkt_words` = 0 → no `rd_fifo`, `src_busy` stays 0. Second `start` pulsed mid-packet → ignored, the packet completes normally.
- `src_reset_n` low in the middle of a 6-word packet:
  - Within the same cycle all outputs = 0 and state is IDLE.
  - After release, a new `start` with a 2-word packet produces a correctly framed packet.
